// File: rtl/voq_rr_scheduler.sv
// Round-robin read scheduler that drains a bank of non-fallthrough VOQ FIFOs onto one
// valid/ready channel, serving up to MAX_BURST words per grant before the pointer rotates.
module voq_rr_scheduler #(
  parameter int NUM_QUEUES = 4,
  parameter int QID_BITS   = 2,
  parameter int WIDTH      = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sched_en,
  input  logic [NUM_QUEUES-1:0]       fifo_empty,
  input  logic [NUM_QUEUES*WIDTH-1:0] fifo_dout,
  output logic [NUM_QUEUES-1:0]       fifo_rd_en,
  output logic [WIDTH-1:0]            out_data,
  output logic [QID_BITS-1:0]         out_qid,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_rdy
);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_e;

  state_e                state_q, state_d;
  logic [QID_BITS-1:0]   grant_q, grant_d;
  logic [QID_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]            burst_cnt_q, burst_cnt_d;
  logic [NUM_QUEUES-1:0] rd_en_q, rd_en_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [QID_BITS-1:0]   out_qid_q, out_qid_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic [WIDTH-1:0]      dout_arr [NUM_QUEUES];
  logic                  pick_found;
  logic [QID_BITS-1:0]   pick_idx;
  logic [QID_BITS-1:0]   scan_idx;
  logic [QID_BITS-1:0]   grant_next;

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_dout
    assign dout_arr[g] = fifo_dout[g*WIDTH +: WIDTH];
  end

  // Scan from the farthest candidate back to rr_ptr so the nearest non-empty queue wins.
  // NOTE: every variable written in a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      scan_idx = QID_BITS'((int'(rr_ptr_q) + k) % NUM_QUEUES);
      if (!fifo_empty[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign grant_next = (grant_q == QID_BITS'(NUM_QUEUES - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    rd_en_d     = '0;
    out_data_d  = out_data_q;
    out_qid_d   = out_qid_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (sched_en && pick_found) begin
          grant_d     = pick_idx;
          rd_en_d     = NUM_QUEUES'(1) << pick_idx;
          burst_cnt_d = '0;
          state_d     = RD;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        // fifo_empty here already reflects the pop, so a drained queue ends the grant.
        out_data_d  = dout_arr[grant_q];
        out_qid_d   = grant_q;
        out_last_d  = (burst_cnt_q == 8'(MAX_BURST - 1)) || fifo_empty[grant_q];
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_rdy) begin
          out_valid_d = 1'b0;
          if (!out_last_q) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
            rd_en_d     = NUM_QUEUES'(1) << grant_q;
            state_d     = RD;
          end else begin
            rr_ptr_d = grant_next;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      rd_en_q     <= '0;
      out_data_q  <= '0;
      out_qid_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      rd_en_q     <= rd_en_d;
      out_data_q  <= out_data_d;
      out_qid_q   <= out_qid_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign out_data   = out_data_q;
  assign out_qid    = out_qid_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Bench for voq_rr_scheduler: a FIFO bank model, a transaction-timing reference model
// checked every cycle, and directed scenarios pinned with literal expectations.
module tb_voq_rr_scheduler;
  localparam int N = 4, QB = 2, W = 32, MB = 4, DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset, sched_en, out_rdy;
  logic [N-1:0]      fifo_empty, fifo_rd_en;
  logic [N*W-1:0]    fifo_dout;
  logic [W-1:0]      out_data;
  logic [QB-1:0]     out_qid;
  logic              out_last, out_valid;

  always #5 clk = ~clk;

  voq_rr_scheduler #(.NUM_QUEUES(N), .QID_BITS(QB), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .out_data(out_data),
    .out_qid(out_qid), .out_last(out_last), .out_valid(out_valid), .out_rdy(out_rdy)
  );

  int n_vec = 0, n_err = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO bank (non-fallthrough, dout valid the cycle after rd_en)
  logic [W-1:0] mem [N][DEPTH];
  int           cnt [N];
  int           head [N];
  logic [W-1:0] dout_r [N];
  logic [N-1:0] wr_req;
  logic [W-1:0] wr_data [N];
  logic [W-1:0] sbq [N][$];

  initial for (int i = 0; i < N; i++) begin cnt[i] = 0; head[i] = 0; dout_r[i] = '0; end

  always_comb begin
    fifo_empty = '0;
    fifo_dout  = '0;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]       = (cnt[i] == 0);
      fifo_dout[i*W +: W] = dout_r[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int c = cnt[i];
      automatic int h = head[i];
      if (fifo_rd_en[i] && c > 0) begin
        dout_r[i] <= mem[i][h];
        h = (h + 1) % DEPTH;
        c--;
      end
      if (wr_req[i]) begin
        mem[i][(h + c) % DEPTH] <= wr_data[i];
        sbq[i].push_back(wr_data[i]);
        c++;
      end
      cnt[i]  <= c;
      head[i] <= h;
    end
  end

  // ---------------- reference model: expected strobe/valid per cycle from the timing rules
  logic          m_busy, m_cap, m_fresh, m_valid, m_last;
  logic [N-1:0]  m_rd, n_rd;
  logic          n_valid, n_fresh;
  logic [QB-1:0] m_grant, m_rr, m_idx;
  int            m_taken;
  logic [W-1:0]  h_data, exp_data;
  logic [QB-1:0] h_qid;
  logic          h_last;
  int            acc_qid[$], acc_last[$];

  always @(negedge clk) begin
    if (reset) begin
      check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
      check("reset_out", 64'({out_valid, out_last, out_qid, out_data}), 64'd0);
      m_busy = 0; m_cap = 0; m_fresh = 0; m_valid = 0; m_last = 0;
      m_rd = '0; m_grant = '0; m_rr = '0; m_taken = 0;
    end else begin
      check("rd_en_onehot0", 64'($onehot0(fifo_rd_en)), 64'd1);
      check("rd_en", 64'(fifo_rd_en), 64'(m_rd));
      check("rd_of_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid && out_valid) begin
        if (m_fresh) begin
          check("sb_has_word", 64'(sbq[m_grant].size() > 0), 64'd1);
          exp_data = (sbq[m_grant].size() > 0) ? sbq[m_grant].pop_front() : '0;
          check("out_data", 64'(out_data), 64'(exp_data));
          check("out_qid", 64'(out_qid), 64'(m_grant));
          check("out_last", 64'(out_last), 64'(m_last));
          h_data = out_data; h_qid = out_qid; h_last = out_last;
        end else begin
          check("out_hold", 64'({out_data, out_qid, out_last}), 64'({h_data, h_qid, h_last}));
        end
      end
      if (out_valid && out_rdy) begin
        acc_qid.push_back(int'(out_qid));
        acc_last.push_back(int'(out_last));
      end

      n_rd = '0; n_valid = m_valid; n_fresh = 0;
      if (!m_busy && sched_en && fifo_empty != '1) begin
        m_idx = m_rr;
        while (fifo_empty[m_idx]) m_idx = QB'((int'(m_idx) + 1) % N);
        m_grant = m_idx; m_busy = 1; m_taken = 0;
        n_rd = N'(1) << m_grant;
      end
      if (m_cap) begin
        m_last  = (m_taken + 1 == MB) || fifo_empty[m_grant];
        n_valid = 1; n_fresh = 1;
      end
      m_cap = (m_rd != '0);
      if (m_valid && out_rdy) begin
        n_valid = 0;
        if (!m_last) begin
          m_taken++;
          n_rd = N'(1) << m_grant;
        end else begin
          m_rr   = QB'((int'(m_grant) + 1) % N);
          m_busy = 0;
        end
      end
      m_rd = n_rd; m_valid = n_valid; m_fresh = n_fresh;
    end
  end

  // ---------------- stimulus helpers
  task automatic cyc_push(logic [N-1:0] mask);
    @(posedge clk); #1;
    wr_req = mask;
    for (int i = 0; i < N; i++) wr_data[i] = $urandom;
  endtask

  task automatic wait_idle(string name, int budget);
    automatic logic done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (fifo_empty == '1) && !out_valid && !m_busy && (fifo_rd_en == '0);
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic wait_acc(string name, int n, int budget);
    for (int c = 0; c < budget && acc_qid.size() < n; c++) @(negedge clk);
    check(name, 64'(acc_qid.size() >= n), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic logic seen;
    reset = 1'b1; sched_en = 1'b1; out_rdy = 1'b1; wr_req = '0;
    for (int i = 0; i < N; i++) wr_data[i] = '0;

    // Reset with every queue loaded: no strobe, all outputs zero.
    repeat (4) cyc_push('1);
    cyc_push('0);
    @(negedge clk);
    check("reset_loaded_rd", 64'(fifo_rd_en), 64'd0);
    check("reset_loaded_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); check("first_idle_rd", 64'(fifo_rd_en), 64'b0000);
    @(negedge clk); check("first_rd", 64'(fifo_rd_en), 64'b0001);
    @(negedge clk); check("first_cap_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_qid", 64'(out_qid), 64'd0);
    wait_idle("drain_initial", 300);

    // Fairness: 8 words per queue, bursts of 4 rotate 0,1,2,3,0,1,2,3.
    @(posedge clk); #1 sched_en = 1'b0;
    repeat (8) cyc_push('1);
    acc_qid.delete(); acc_last.delete();
    @(posedge clk); #1 wr_req = '0; sched_en = 1'b1;
    wait_acc("fair_count", 32, 400);
    for (int j = 0; j < 32 && j < acc_qid.size(); j++) begin
      check($sformatf("fair_qid_%0d", j), 64'(acc_qid[j]), 64'((j / 4) % 4));
      check($sformatf("fair_last_%0d", j), 64'(acc_last[j]), 64'(j % 4 == 3));
    end
    wait_idle("drain_fair", 100);

    // Short queue 2 with ten cycles of backpressure on its first word.
    @(posedge clk); #1 sched_en = 1'b0; out_rdy = 1'b0;
    acc_qid.delete(); acc_last.delete();
    repeat (2) cyc_push(4'b0100);
    @(posedge clk); #1 wr_req = '0; sched_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = out_valid; end
    check("bp_valid_seen", 64'(seen), 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_no_rd", 64'(fifo_rd_en), 64'd0);
      check("bp_qid", 64'(out_qid), 64'd2);
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    wait_acc("short_count", 2, 50);
    if (acc_qid.size() >= 2) begin
      check("short_qid0", 64'(acc_qid[0]), 64'd2);
      check("short_qid1", 64'(acc_qid[1]), 64'd2);
      check("short_last0", 64'(acc_last[0]), 64'd0);
      check("short_last1", 64'(acc_last[1]), 64'd1);
    end
    wait_idle("drain_short", 50);
    check("short_rr_ptr", 64'(m_rr), 64'd3);

    // Wrap-around: pointer at 3, queues 3 and 1 loaded -> grant 3 then 1.
    @(posedge clk); #1 sched_en = 1'b0;
    acc_qid.delete(); acc_last.delete();
    cyc_push(4'b1010);
    @(posedge clk); #1 wr_req = '0; sched_en = 1'b1;
    wait_acc("wrap_count", 2, 50);
    if (acc_qid.size() >= 2) begin
      check("wrap_qid0", 64'(acc_qid[0]), 64'd3);
      check("wrap_qid1", 64'(acc_qid[1]), 64'd1);
      check("wrap_lasts", 64'(acc_last[0] + acc_last[1]), 64'd2);
    end
    wait_idle("drain_wrap", 50);
    check("wrap_rr_ptr", 64'(m_rr), 64'd2);

    // Randomized traffic, enable and backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        wr_req[i]  = (cnt[i] < DEPTH - 2) && ($urandom_range(0, 3) == 0);
        wr_data[i] = $urandom;
      end
      sched_en = ($urandom_range(0, 9) != 0);
      out_rdy  = ($urandom_range(0, 3) != 0);
    end

    // Reset asserted during a read strobe clears it immediately.
    @(posedge clk); #1 sched_en = 1'b1; out_rdy = 1'b1;
    wr_req = 4'b0001; wr_data[0] = $urandom;
    @(posedge clk); #1 wr_req = '0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); seen = (fifo_rd_en != '0); end
    check("mid_rd_seen", 64'(seen), 64'd1);
    #1 reset = 1'b1;
    #1 check("async_rst_rd", 64'(fifo_rd_en), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle("drain_final", 2000);
    check("sb_empty", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/voq_rr_scheduler.md
# voq_rr_scheduler

Round-robin read scheduler that shares one output channel among NUM_QUEUES non-fallthrough small FIFOs (virtual output queues). It selects a non-empty queue with an iSLIP-style rotating pointer, drives that FIFO's read enable, captures the word one cycle later and presents it on a valid/ready output. It sits between the per-input VOQ FIFO bank and the crossbar/output stage.

## Interface
- NUM_QUEUES, 4: number of FIFOs arbitrated; any value ≥ 2, not required to be a power of two.
- QID_BITS, 2: width of queue index; must satisfy 2**QID_BITS ≥ NUM_QUEUES.
- WIDTH, 32: data word width, equal to the FIFO WIDTH.
- MAX_BURST, 4: maximum words taken from one queue per grant; range 1..255.

- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sched_en  in  1  when low, no new grant starts; a burst in progress completes.
- fifo_empty  in  NUM_QUEUES  empty flag of each FIFO, bit i = queue i.
- fifo_dout  in  NUM_QUEUES*WIDTH  FIFO data, queue i at bits [i*WIDTH +: WIDTH]; valid the cycle after its rd_en.
- fifo_rd_en  out  NUM_QUEUES  registered one-hot read strobe, at most one bit high.
- out_data  out  WIDTH  registered captured word.
- out_qid  out  QID_BITS  queue index of out_data.
- out_last  out  1  high with the final word of a grant.
- out_valid  out  1  out_data/out_qid/out_last valid.
- out_rdy  in  1  downstream accepts when out_valid & out_rdy.

## Operation
- Registers: state, grant (QID_BITS), rr_ptr (QID_BITS), burst_cnt (8 bits), fifo_rd_en, out_*. Reset values: state IDLE, all others 0; every output 0 while reset is high.
- IDLE: if sched_en and any fifo_empty bit low, grant <= first non-empty index scanning rr_ptr, rr_ptr+1, … modulo NUM_QUEUES (wrap NUM_QUEUES-1 -> 0); fifo_rd_en <= onehot(new grant); burst_cnt <= 0; -> RD. Otherwise stay.
- RD: fifo_rd_en is high for exactly this cycle; fifo_rd_en <= 0; -> CAP.
- CAP: out_data <= fifo_dout slice of grant; out_qid <= grant; out_last <= (burst_cnt == MAX_BURST-1) or fifo_empty[grant]; out_valid <= 1; -> OUT.
- OUT: hold all out_* stable while out_rdy is low. On out_valid & out_rdy: out_valid <= 0; if out_last is low, burst_cnt <= burst_cnt+1, fifo_rd_en <= onehot(grant), -> RD; else rr_ptr <= (grant+1) mod NUM_QUEUES, -> IDLE.
- Pointer moves only at grant end (one beyond the served queue); a queue found empty is skipped without moving rr_ptr.
- fifo_empty[grant] sampled in CAP already reflects the read done at the RD edge, so out_last never causes a read of an empty FIFO.
- sched_en low affects only the IDLE decision.
- Scheduler never reads a FIFO flagged empty; at most one rd_en bit high in any cycle.

## Timing
- Queue non-empty in IDLE cycle T -> fifo_rd_en high cycle T+1 -> out_valid high cycle T+3 (earliest).
- Within a burst with out_rdy held high: one word every 3 cycles (OUT, RD, CAP).
- Grant end to next grant: OUT accept -> IDLE (1 cycle) -> RD; new rd_en 2 cycles after last accept.
- Reset asserted mid-burst: fifo_rd_en, out_valid drop asynchronously; pending captured word is discarded; rr_ptr returns to 0.
- Simultaneous empty-going and new write on the granted queue: decision uses fifo_empty as seen in CAP only.

## Test plan
- Reset: assert reset with all queues full -> all outputs 0, no rd_en; release -> grant queue 0, rd_en=4'b0001 one cycle later, out_valid 3 cycles after first IDLE sample.
- Fairness: queues 0..3 each hold 8 words, MAX_BURST=4, out_rdy=1 -> out_qid sequence 0×4,1×4,2×4,3×4,0×4,…; out_last on every 4th word.
- Short queue: only queue 2 holds 2 words, rr_ptr=0 -> two words qid 2, second with out_last=1; rr_ptr becomes 3; no rd_en while empty.
- Wrap-around: rr_ptr=3, queues 3 and 1 non-empty -> grant 3 first, then rr_ptr=0, grant 1, rr_ptr=2.
- Backpressure: out_rdy low 10 cycles during OUT -> out_data/out_qid/out_last stable, no rd_en; accept on rdy high, burst continues.
- sched_en low mid-burst -> burst completes to out_last, then no new grant until sched_en high; reset mid-RD -> rd_en cleared immediately.
